// File: rtl/decoder_pkg.sv
// Shared RV32I decode definitions: opcodes, ALUOp encodings and the control bundle.
package decoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_R      = 2'b10;
  localparam logic [1:0] ALUOP_IALU   = 2'b11;

  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Only these classes actually read rs2; I-type immediates occupy that field.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode to control-bundle decoder.
module decode_ctrl
  import decoder_pkg::*;
(
  input  logic [6:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (opcode_i)
      OP_R: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_R;
      end
      OP_IALU: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_IALU;
      end
      OP_LOAD: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_BRANCH: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALUOP_BRANCH;
      end
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_JALR: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// Registered RV32I decode stage with ID/EX handshake and flush.
// LOAD_USE_STALL_EN enables load-use bubble insertion and the saturating bubble counter.
module id_decode_stage
  import decoder_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              flush_i,
  input  logic              ex_ready_i,
  output logic              ctrl_valid_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic              Branch_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemtoReg_o,
  output logic              Jump_o,
  output logic [1:0]        ALUOp_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              illegal_o,
  output logic              load_use_stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  ctrl_t             w_ctrl;
  logic [6:0]        w_opcode;
  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  logic              w_hazard, w_stall, w_accept;
  logic [9:0]        w_unused_funct;

  ctrl_t             r_ctrl;
  logic              r_valid;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;

  assign w_opcode       = instr_i[6:0];
  assign w_rd           = instr_i[7 +: REG_AW];
  assign w_rs1          = instr_i[15 +: REG_AW];
  assign w_rs2          = instr_i[20 +: REG_AW];
  assign w_unused_funct = {instr_i[31:25], instr_i[14:12]};

  decode_ctrl u_decode_ctrl (
    .opcode_i (w_opcode),
    .ctrl_o   (w_ctrl)
  );

`ifdef LOAD_USE_STALL_EN
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_hazard = r_valid && r_ctrl.mem_read && (r_rd != '0) && instr_valid_i &&
                    ((r_rd == w_rs1) || ((r_rd == w_rs2) && uses_rs2(w_opcode)));

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign w_hazard    = 1'b0;
  assign stall_cnt_o = '0;
`endif

  assign w_stall          = w_hazard && ex_ready_i && !flush_i;
  assign load_use_stall_o = w_stall;
  assign instr_ready_o    = !flush_i && !w_hazard && (!r_valid || ex_ready_i);
  assign w_accept         = instr_valid_i && instr_ready_o;

  // Flush and bubble both issue an empty bundle; register fields are don't-care then.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (flush_i || w_stall) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_rd    <= w_rd;
    end else if (ex_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign ctrl_valid_o = r_valid;
  assign ALUSrc_o     = r_ctrl.alu_src;
  assign RegWrite_o   = r_ctrl.reg_write;
  assign Branch_o     = r_ctrl.branch;
  assign MemRead_o    = r_ctrl.mem_read;
  assign MemWrite_o   = r_ctrl.mem_write;
  assign MemtoReg_o   = r_ctrl.mem_to_reg;
  assign Jump_o       = r_ctrl.jump;
  assign ALUOp_o      = r_ctrl.alu_op;
  assign illegal_o    = r_ctrl.illegal;
  assign rs1_o        = r_rs1;
  assign rs2_o        = r_rs2;
  assign rd_o         = r_rd;

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered RV32I instruction-decode stage that sits between the IF/ID instruction register and the execute stage. It turns each instruction into a full control bundle covering all base classes (R, I-ALU, load, store, branch, JAL, JALR) plus register addresses. The bundle is held in an ID/EX output register with a valid/ready handshake, synchronous flush, and optional load-use hazard stalling with a saturating stall counter.

## Interface
- CNT_W, 16, width of the saturating bubble counter
- REG_AW, 5, register-address width (rs1/rs2/rd fields)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- instr_i  in  32  instruction from IF/ID
- instr_valid_i  in  1  instr_i holds a valid instruction
- instr_ready_o  out  1  stage accepts instr_i this cycle
- flush_i  in  1  discard the ID/EX contents and the incoming instruction (taken branch/jump)
- ex_ready_i  in  1  execute stage consumes the bundle this cycle
- ctrl_valid_o  out  1  output bundle valid
- ALUSrc_o, RegWrite_o, Branch_o, MemRead_o, MemWrite_o, MemtoReg_o, Jump_o  out  1 each  control bits
- ALUOp_o  out  2  00 add (load/store/jump), 01 branch, 10 R-type, 11 I-ALU
- rs1_o, rs2_o, rd_o  out  REG_AW  instr[19:15], [24:20], [11:7]
- illegal_o  out  1  opcode not in the decoded set
- load_use_stall_o  out  1  hazard bubble being inserted this cycle
- stall_cnt_o  out  CNT_W  bubbles inserted since reset, saturating

## Operation
- Opcode map: 0110011 → RegWrite, ALUOp 10.
- 0010011 → ALUSrc, RegWrite, ALUOp 11.
- 0000011 → ALUSrc, RegWrite, MemRead, MemtoReg, ALUOp 00.
- 0100011 → ALUSrc, MemWrite, ALUOp 00.
- 1100011 → Branch, ALUOp 01.
- 1101111 → Jump, RegWrite, ALUOp 00.
- 1100111 → Jump, ALUSrc, RegWrite, ALUOp 00.
- Any other opcode → all control bits 0, ALUOp 00, illegal_o 1. The bundle is still issued with ctrl_valid_o 1.
- Accept: instr_valid_i && instr_ready_o. The decoded bundle is written into the output register at the next edge.
- instr_ready_o = !flush_i && !hazard && (!ctrl_valid_o || ex_ready_i).
- Hold: when ctrl_valid_o && !ex_ready_i, the output register and all outputs are stable.
- Hazard (combinational): ctrl_valid_o && MemRead_o && rd_o != 0 && instr_valid_i && (rd_o == rs1 of instr_i || (rd_o == rs2 of instr_i && incoming opcode is R, store or branch)).
- Bubble on hazard with ex_ready_i: the output register loads ctrl_valid_o 0 with all control bits 0, and stall_cnt_o increments. The following cycle the hazard is gone and the instruction is accepted.
- Hazard without ex_ready_i: plain hold; no increment.
- stall_cnt_o saturates at 2^CNT_W−1.
- Flush: ctrl_valid_o ← 0 and control bits ← 0; the incoming instruction is dropped; no counter change.
- Priority: rst_i > flush_i > hazard > normal.

## Timing
- Latency: 1 cycle from acceptance to ctrl_valid_o.
- Throughput: 1 instruction/cycle without hazards; a load-use pair costs exactly 1 bubble.
- Reset values:
  - ctrl_valid_o, all control bits, ALUOp_o, rs1_o/rs2_o/rd_o, illegal_o: 0.
  - stall_cnt_o: 0; load_use_stall_o: 0.
- load_use_stall_o is combinational: equal to hazard && ex_ready_i && !flush_i.
- Reset mid-stall: the pending instruction is discarded; IF must re-present it.

## Configuration
- LOAD_USE_STALL_EN defined: hazard logic, load_use_stall_o and stall_cnt_o behave as above.
- LOAD_USE_STALL_EN undefined: hazard is constant 0, load_use_stall_o tied 0, and stall_cnt_o tied 0. Forwarding/interlock is then external.

## Structure
- Shared package decoder_pkg holds:
  - opcode localparams (OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR);
  - ALUOp encodings;
  - packed struct ctrl_t (seven control bits, ALUOp, illegal).
- Sub-module decode_ctrl: purely combinational opcode → ctrl_t. The top holds the handshake, output register, hazard logic and counter.

## Test plan
- R-type add x3,x1,x2 (0x002081B3), ex_ready_i=1 → next cycle ctrl_valid_o=1, RegWrite=1, ALUSrc=0, ALUOp=10, rd_o=3.
- lw x5,0(x1) then add x6,x5,x2 back-to-back → one cycle with ctrl_valid_o=0 and load_use_stall_o=1, stall_cnt_o=1, then add issues. With the macro off: no bubble, stall_cnt_o=0.
- lw x5 then addi x6,x0,5 (rs1=x0, no rs2 use) → no bubble; lw x0 followed by a use of x0 → no bubble.
- ex_ready_i=0 for 3 cycles with a valid sw bundle → outputs stable and instr_ready_o=0; on release, the next instruction is accepted.
- flush_i during acceptance of jal → next cycle ctrl_valid_o=0, jal dropped; rst_i and flush_i together → reset values.
- Opcode 0x7F → ctrl_valid_o=1, illegal_o=1, all control bits 0.
